// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg: opcode encodings and default latencies for the EX-stage arithmetic unit
package alu_muldiv_pkg;
    localparam int DEF_MUL_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 10;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_OR, ALU_LUI, ALU_XOR, ALU_AND,
        ALU_NOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;
    typedef enum logic [2:0] {
        CMP_ALWAYS, CMP_EQ, CMP_NE, CMP_LEZ, CMP_GTZ, CMP_LTZ, CMP_GEZ, CMP_NEVER
    } cmp_op_e;
    typedef enum logic [2:0] {
        MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_NOP
    } md_op_e;
    function automatic logic is_div(input logic [2:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction
endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: EX-stage operand/result bundle between pipeline and arithmetic unit
interface alu_muldiv_if #(parameter int WIDTH = 32);
    logic [3:0]       ALUctr;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [2:0]       cmp_op;
    logic [2:0]       MDop;
    logic             start;
    logic             zero;
    logic [WIDTH-1:0] ALUResult;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    modport master (output ALUctr, SrcA, SrcB, cmp_op, MDop, start,
                    input  zero, ALUResult, busy, HI, LO);
    modport slave  (input  ALUctr, SrcA, SrcB, cmp_op, MDop, start,
                    output zero, ALUResult, busy, HI, LO);
endinterface

// File: rtl/alu_muldiv_muldiv_unit.sv
// alu_muldiv_muldiv_unit: multi-cycle mult/div engine with HI/LO registers
module alu_muldiv_muldiv_unit
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       MDop,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int MAXC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    logic [WIDTH-1:0]   a_q, b_q, a_mag, b_mag, quo_mag, rem_mag, quo, rem;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [2:0]         op_q;
    logic [CW-1:0]      cnt;
    logic               sgn, a_neg, b_neg, done, accept;
    // Work on magnitudes so MIN/-1 falls out naturally as MIN with remainder 0
    assign sgn      = op_q == MD_MULT || op_q == MD_DIV;
    assign a_neg    = sgn & a_q[WIDTH-1];
    assign b_neg    = sgn & b_q[WIDTH-1];
    assign a_mag    = a_neg ? -a_q : a_q;
    assign b_mag    = b_neg ? -b_q : b_q;
    assign prod_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    assign prod     = (a_neg ^ b_neg) ? -prod_mag : prod_mag;
    assign quo_mag  = (b_mag == '0) ? '0 : a_mag / b_mag;
    assign rem_mag  = (b_mag == '0) ? '0 : a_mag % b_mag;
    assign quo      = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    assign rem      = a_neg ? -rem_mag : rem_mag;
    assign done     = busy && cnt == CW'(1);
    // A new op may chain on the edge the current one retires
    assign accept   = start && (!busy || done) && MDop inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= MD_NONE;
            cnt  <= '0;
            busy <= 1'b0;
            HI   <= '0;
            LO   <= '0;
        end else begin
            if (busy) cnt <= cnt - CW'(1);
            if (done) begin
                busy <= 1'b0;
                if (!is_div(op_q)) {HI, LO} <= prod;
                else if (b_q != '0) begin
                    HI <= rem;
                    LO <= quo;
                end
            end
            if (accept) begin
                a_q  <= SrcA;
                b_q  <= SrcB;
                op_q <= MDop;
                cnt  <= is_div(MDop) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                busy <= 1'b1;
            end else if (start && !busy && MDop == MD_MTHI) HI <= SrcA;
            else if (start && !busy && MDop == MD_MTLO) LO <= SrcA;
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU, branch comparator and multi-cycle mult/div with HI/LO
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input logic        clk,
    input logic        reset,
    alu_muldiv_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    logic [WIDTH-1:0] a, b, res;
    logic [SW-1:0]    shamt;
    logic             cond;
    assign a     = bus.SrcA;
    assign b     = bus.SrcB;
    assign shamt = a[SW-1:0];
    always_comb begin
        res = '0;
        case (bus.ALUctr)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_OR:   res = a | b;
            ALU_LUI:  res = b << (WIDTH - 16);
            ALU_XOR:  res = a ^ b;
            ALU_AND:  res = a & b;
            ALU_NOR:  res = ~(a | b);
            ALU_SLT:  res = WIDTH'($signed(a) < $signed(b));
            ALU_SLTU: res = WIDTH'(a < b);
            ALU_SLL:  res = b << shamt;
            ALU_SRL:  res = b >> shamt;
            ALU_SRA:  res = $signed(b) >>> shamt;
            default:  res = '0;
        endcase
    end
    always_comb begin
        cond = 1'b0;
        case (bus.cmp_op)
            CMP_ALWAYS: cond = 1'b1;
            CMP_EQ:     cond = a == b;
            CMP_NE:     cond = a != b;
            CMP_LEZ:    cond = a[WIDTH-1] || a == '0;
            CMP_GTZ:    cond = !a[WIDTH-1] && a != '0;
            CMP_LTZ:    cond = a[WIDTH-1];
            CMP_GEZ:    cond = !a[WIDTH-1];
            default:    cond = 1'b0;
        endcase
    end
    assign bus.ALUResult = res;
    assign bus.zero      = cond;
    alu_muldiv_muldiv_unit #(
        .WIDTH(WIDTH),
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_muldiv (
        .clk(clk),
        .reset(reset),
        .start(bus.start),
        .MDop(bus.MDop),
        .SrcA(bus.SrcA),
        .SrcB(bus.SrcB),
        .busy(bus.busy),
        .HI(bus.HI),
        .LO(bus.LO)
    );
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: randomized self-checking bench against an arithmetic reference model
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [31:0] hi_m = '0, lo_m = '0;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    alu_muldiv_if #(.WIDTH(32)) bus();
    alu_muldiv #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint lb;
        int sh;
        sa = $signed(a);
        sb = $signed(b);
        lb = sb;
        sh = int'(a % 32);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a | b;
            3: return {b[15:0], 16'h0};
            4: return a ^ b;
            5: return a & b;
            6: return ~(a | b);
            7: return (sa < sb) ? 1 : 0;
            8: return (a < b) ? 1 : 0;
            9: return b << sh;
            10: return b >> sh;
            11: return 32'(lb >>> sh);
            default: return 0;
        endcase
    endfunction
    function automatic logic cmp_ref(input int op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = $signed(a);
        case (op)
            0: return 1;
            1: return a == b;
            2: return a != b;
            3: return sa <= 0;
            4: return sa > 0;
            5: return sa < 0;
            6: return sa >= 0;
            default: return 0;
        endcase
    endfunction
    function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [63:0] hilo);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            1: return sa * sb;
            2: return ua * ub;
            3: return (b == 0) ? hilo : {32'(sa % sb), 32'(sa / sb)};
            4: return (b == 0) ? hilo : {32'(ua % ub), 32'(ua / ub)};
            default: return hilo;
        endcase
    endfunction
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.MDop  = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        bus.start = 1'b1;
    endtask
    // Called in the first cycle after the accepting edge; optionally pokes ignored ops or chains a new one
    task automatic track(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject,
                         input bit chain, input logic [2:0] cop, input logic [31:0] ca, input logic [31:0] cb);
        int n;
        n = is_div(op) ? 10 : 5;
        bus.start = 1'b0;
        for (int i = 1; i <= n; i++) begin
            check("busy_run", bus.busy, 1);
            if (inject && i == 2) drive(MD_DIV, 32'd99, 32'd3);
            if (inject && i == 3) drive(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
            if (chain && i == n) drive(cop, ca, cb);
            step;
            bus.start = 1'b0;
        end
        {hi_m, lo_m} = md_ref(op, a, b, {hi_m, lo_m});
        check("busy_end", bus.busy, chain);
        check("hi", bus.HI, hi_m);
        check("lo", bus.LO, lo_m);
    endtask
    initial begin
        bus.ALUctr = 0; bus.SrcA = 0; bus.SrcB = 0; bus.cmp_op = 0; bus.MDop = 0; bus.start = 0;
        step;
        step;
        reset = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_hi", bus.HI, 0);
        check("rst_lo", bus.LO, 0);
        bus.SrcA = 32'hFFFF_FFFF; bus.SrcB = 32'd1;
        bus.ALUctr = ALU_ADD;  #1 check("add", bus.ALUResult, 32'h0);
        bus.ALUctr = ALU_SUB;  #1 check("sub", bus.ALUResult, 32'hFFFF_FFFE);
        bus.ALUctr = ALU_SLTU; #1 check("sltu", bus.ALUResult, 32'h0);
        bus.ALUctr = ALU_SLT;  #1 check("slt", bus.ALUResult, 32'h1);
        bus.SrcB = 32'h1234; bus.ALUctr = ALU_LUI; #1 check("lui", bus.ALUResult, 32'h1234_0000);
        bus.SrcA = 32'd4; bus.SrcB = 32'h8000_0000; bus.ALUctr = ALU_SRA;
        #1 check("sra", bus.ALUResult, 32'hF800_0000);
        for (int t = 0; t < 60; t++) begin
            bus.ALUctr = 4'($urandom_range(0, 15));
            bus.SrcA = $urandom;
            bus.SrcB = $urandom;
            #1 check("alu_rand", bus.ALUResult, alu_ref(int'(bus.ALUctr), bus.SrcA, bus.SrcB));
        end
        bus.SrcA = 32'd7; bus.SrcB = 32'd7;
        bus.cmp_op = CMP_EQ; #1 check("cmp_eq", bus.zero, 1);
        bus.cmp_op = CMP_NE; #1 check("cmp_ne", bus.zero, 0);
        bus.SrcA = 32'h8000_0000;
        bus.cmp_op = CMP_LTZ; #1 check("cmp_ltz", bus.zero, 1);
        bus.cmp_op = CMP_GTZ; #1 check("cmp_gtz", bus.zero, 0);
        for (int t = 0; t < 60; t++) begin
            bus.cmp_op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: bus.SrcA = 32'h0;
                1: bus.SrcA = 32'h8000_0000;
                default: bus.SrcA = $urandom;
            endcase
            bus.SrcB = ($urandom_range(0, 1) == 1) ? bus.SrcA : $urandom;
            #1 check("cmp_rand", bus.zero, cmp_ref(int'(bus.cmp_op), bus.SrcA, bus.SrcB));
        end
        step;
        drive(MD_MULT, -32'sd3, 32'd5);
        step;
        track(MD_MULT, -32'sd3, 32'd5, 1, 0, 0, 0, 0);
        check("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check("mult_lo", bus.LO, 32'hFFFF_FFF1);
        drive(MD_DIV, -32'sd7, 32'd2);
        step;
        track(MD_DIV, -32'sd7, 32'd2, 0, 0, 0, 0, 0);
        check("div_lo", bus.LO, 32'hFFFF_FFFD);
        check("div_hi", bus.HI, 32'hFFFF_FFFF);
        drive(MD_DIVU, 32'd7, 32'd0);
        step;
        track(MD_DIVU, 32'd7, 32'd0, 0, 0, 0, 0, 0);
        check("div0_lo", bus.LO, 32'hFFFF_FFFD);
        drive(MD_MTHI, 32'hA5A5_A5A5, 32'd0);
        step;
        check("mthi_early", bus.HI, 32'hA5A5_A5A5);
        drive(MD_MTLO, 32'h5A5A_5A5A, 32'd0);
        step;
        bus.start = 1'b0;
        hi_m = 32'hA5A5_A5A5; lo_m = 32'h5A5A_5A5A;
        check("mt_hi", bus.HI, hi_m);
        check("mt_lo", bus.LO, lo_m);
        check("mt_busy", bus.busy, 0);
        drive(MD_MULTU, 32'hFFFF_FFFF, 32'h2);
        step;
        bus.start = 1'b0;
        step;
        step;
        reset = 1'b1;
        drive(MD_MULT, 32'd3, 32'd3);
        step;
        reset = 1'b0;
        bus.start = 1'b0;
        hi_m = '0; lo_m = '0;
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_hi", bus.HI, 0);
        check("rst_mid_lo", bus.LO, 0);
        step;
        check("rst_mid_idle", bus.busy, 0);
        drive(MD_MULT, 32'd1234, -32'sd77);
        step;
        track(MD_MULT, 32'd1234, -32'sd77, 0, 1, MD_MULTU, 32'h8000_0001, 32'hFFFF_FFFF);
        track(MD_MULTU, 32'h8000_0001, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        for (int t = 0; t < 24; t++) begin
            r_op = 3'($urandom_range(1, 6));
            r_a = $urandom;
            r_b = $urandom;
            case ($urandom_range(0, 3))
                0: r_b = 32'd0;
                1: r_b = $urandom_range(1, 50);
                default: ;
            endcase
            if (t == 5) begin
                r_op = MD_DIV; r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF;
            end
            drive(r_op, r_a, r_b);
            step;
            bus.start = 1'b0;
            if (r_op >= 3'd5) begin
                if (r_op == 3'd5) hi_m = r_a;
                else lo_m = r_a;
                check("rnd_mt_busy", bus.busy, 0);
                check("rnd_mt_hi", bus.HI, hi_m);
                check("rnd_mt_lo", bus.LO, lo_m);
            end else track(r_op, r_a, r_b, t[0], 0, 0, 0, 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
